mario_motion_ctrl: RTL and testbench
====================================

# mario_motion_ctrl

Frame-rate motion and animation controller for the Mario sprite. It turns player buttons into the sprite's top-left position (`curr_h`, `curr_v`) and sprite-select code (stand / move / jump) consumed by the sprite position/draw stage of the VGA controller. All state advances once per video frame, on a one-cycle `frame_tick` pulse. The block implements horizontal walking with clamping, walk-cycle animation, and a fixed-arc jump.

## Interface
Parameters:
- `H_START`, 40: horizontal reset position (pixels).
- `V_START`, 416: vertical reset position and ground line.
- `H_MIN`, 0: leftmost allowed `curr_h`.
- `H_MAX`, 608: rightmost allowed `curr_h` (640 − 32).
- `STEP`, 2: horizontal pixels per frame while walking.
- `JUMP_STEP`, 4: vertical pixels per frame while jumping.
- `JUMP_FRAMES`, 8: frames spent rising; descent takes the same number of frames.
- `ANIM_FRAMES`, 6: frames per walk-animation phase.

Ports:
- `clk` in 1: system clock (pixel clock domain).
- `rst_n` in 1: reset, asynchronous and active-low.
- `frame_tick` in 1: one-cycle pulse per frame, at vsync start.
- `btn_left` in 1: move left, level, synchronous to `clk`.
- `btn_right` in 1: move right, level.
- `btn_jump` in 1: jump request, level; a jump is triggered on its rising edge.
- `curr_h` out 10: sprite top-left x.
- `curr_v` out 10: sprite top-left y.
- `sprite_selec` out 2: sprite code. 00 = stand, 01 = move, 10 = jump. 11 is never driven.
- `facing_left` out 1: last horizontal direction. 1 = left.

## Operation
- States:
  - STAND
  - WALK
  - JUMP_UP
  - JUMP_DOWN
- Every state and register update happens only on cycles with `frame_tick`=1. Between ticks, all registers hold.
- Horizontal direction `dir` is derived each tick:
  - left only → −1.
  - right only → +1.
  - neither, or both → 0.
- STAND:
  - A jump edge (`btn_jump`=1 with the previous tick's sample 0) has priority. The block captures `ground_v`=`curr_v`, clears `jcnt`, and goes to JUMP_UP.
  - Otherwise, `dir`≠0 → WALK, and the first step is applied on this same tick.
  - Otherwise it stays in STAND.
- WALK:
  - A jump edge has the same priority as in STAND.
  - `dir`=0 → STAND.
  - Otherwise `curr_h` moves by `STEP` and the animation counter increments.
- Animation counter:
  - Runs from 0 to `ANIM_FRAMES`−1, then wraps.
  - On each wrap, the phase bit toggles.
  - `sprite_selec` = 01 when the phase bit is 1, otherwise 00.
  - The counter and phase clear on entry to STAND.
- JUMP_UP:
  - Each tick: `curr_v` −= `JUMP_STEP` and `jcnt`++.
  - When `jcnt` reaches `JUMP_FRAMES`, `jcnt` clears and the state becomes JUMP_DOWN.
- JUMP_DOWN:
  - Each tick: `curr_v` += `JUMP_STEP` and `jcnt`++.
  - When `jcnt` reaches `JUMP_FRAMES`, `curr_v` is forced to `ground_v` and the state becomes STAND.
  - A jump edge arriving during the jump is ignored, and is not queued.
- `sprite_selec` = 10 throughout JUMP_UP and JUMP_DOWN.
- Horizontal arithmetic:
  - Computed at 11 bits, then clamped into [`H_MIN`, `H_MAX`]. No wrap-around.
  - Left motion at `H_MIN` holds at `H_MIN`; right motion at `H_MAX` holds at `H_MAX`.
  - The walk animation still runs while pinned against a limit.
- `facing_left` updates whenever `dir`≠0, in any state where horizontal input is accepted.
- The jump-edge history register samples `btn_jump` on every tick, in every state.

## Timing
- Reset values:
  - `curr_h`=`H_START`, `curr_v`=`V_START`.
  - `sprite_selec`=00, `facing_left`=0.
  - State STAND; all counters 0; edge history 0.
- Latency: all outputs are registered and change on the `clk` edge that samples `frame_tick`=1. They are visible on the following cycle.
- A full jump lasts 2×`JUMP_FRAMES` ticks. Peak `curr_v` = `ground_v` − `JUMP_STEP`×`JUMP_FRAMES`.
- Reset asserted mid-jump or mid-walk immediately restores all reset values. No partial arc is resumed.
- A button pulse that does not overlap a `frame_tick` cycle is never seen.

## Configuration
- `MARIO_AIR_CONTROL_EN` defined: in JUMP_UP and JUMP_DOWN, `dir` moves `curr_h` by `STEP` per tick (clamped) and updates `facing_left`. `sprite_selec` stays 10.
- Undefined: `curr_h` and `facing_left` are frozen for the whole jump.

## Structure
- Shared package `mario_pkg`:
  - State enum `mario_state_t`.
  - Sprite codes `SPR_STAND`=2'b00, `SPR_MOVE`=2'b01, `SPR_JUMP`=2'b10.
  - Screen constants 640 and 480, and sprite size 32.
- One sub-module, `mario_frame_cnt`: a parameterised tick-enabled counter with terminal-count pulse and synchronous clear. It is instantiated twice, for animation (`ANIM_FRAMES`) and jump (`JUMP_FRAMES`).

## Test plan
- Reset, then 3 ticks with no buttons → `curr_h`=40, `curr_v`=416, `sprite_selec`=00 throughout.
- `btn_right` held for 12 ticks → `curr_h`=64. `sprite_selec` is 00 for ticks 1–5, 01 for ticks 6–11, and 00 from tick 12. `facing_left`=0.
- `btn_left` held 30 ticks from `curr_h`=40 → `curr_h` reaches 10 after 15 ticks, then holds at 0 from tick 20 on. `facing_left`=1.
- `btn_jump` rises at rest → `curr_v` goes 412, 408 … 384 over 8 ticks, then back to 416 after 8 more. `sprite_selec`=10 for 16 ticks, then 00. A second rise at tick 5 is ignored.
- Jump with `btn_right` held → without the macro, `curr_h` is unchanged for 16 ticks. With `MARIO_AIR_CONTROL_EN`, `curr_h` rises by 32.
- `rst_n` pulsed low at jump tick 4 → outputs return to 40/416/00 asynchronously. The first tick after release with `btn_jump` still high does not jump.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario motion/animation controller.
package mario_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned SPRITE_SZ = 32;

  localparam int unsigned POS_W    = 10;
  localparam int unsigned H_CALC_W = 11;

  typedef enum logic [1:0] {
    ST_STAND     = 2'd0,
    ST_WALK      = 2'd1,
    ST_JUMP_UP   = 2'd2,
    ST_JUMP_DOWN = 2'd3
  } mario_state_t;

  localparam logic [1:0] SPR_STAND = 2'b00;
  localparam logic [1:0] SPR_MOVE  = 2'b01;
  localparam logic [1:0] SPR_JUMP  = 2'b10;

  // Saturate a signed horizontal candidate into [lo, hi]; never wraps.
  function automatic logic [POS_W-1:0] clamp_h(
    input logic signed [H_CALC_W-1:0] x,
    input logic signed [H_CALC_W-1:0] lo,
    input logic signed [H_CALC_W-1:0] hi
  );
    if (x < lo) begin
      return POS_W'(lo);
    end else if (x > hi) begin
      return POS_W'(hi);
    end
    return POS_W'(x);
  endfunction

endpackage

// File: rtl/mario_frame_cnt.sv
// Frame-enabled modulo-MAX counter with synchronous clear and a wrap pulse.
module mario_frame_cnt #(
  parameter int unsigned MAX = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap_c
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last   = (r_cnt == W'(MAX - 1));
  assign o_wrap_c = i_en & ~i_clr & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame walk / jump controller producing Mario's sprite position and code.
// Optional build macro: MARIO_AIR_CONTROL_EN (horizontal steering while airborne).
module mario_motion_ctrl
  import mario_pkg::*;
#(
  parameter int unsigned H_START     = 40,
  parameter int unsigned V_START     = SCREEN_H - 2 * SPRITE_SZ,
  parameter int unsigned H_MIN       = 0,
  parameter int unsigned H_MAX       = SCREEN_W - SPRITE_SZ,
  parameter int unsigned STEP        = 2,
  parameter int unsigned JUMP_STEP   = 4,
  parameter int unsigned JUMP_FRAMES = 8,
  parameter int unsigned ANIM_FRAMES = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [POS_W-1:0] curr_h,
  output logic [POS_W-1:0] curr_v,
  output logic [1:0]       sprite_selec,
  output logic             facing_left
);

`ifdef MARIO_AIR_CONTROL_EN
  localparam bit AIR_CTRL = 1'b1;
`else
  localparam bit AIR_CTRL = 1'b0;
`endif

  mario_state_t r_state, w_state_nxt;

  logic [POS_W-1:0] r_curr_h, r_curr_v, r_ground_v;
  logic [POS_W-1:0] w_h_nxt, w_v_nxt, w_ground_nxt, w_h_step;
  logic [1:0]       r_sprite, w_sprite_nxt;
  logic             r_facing, w_face_nxt;
  logic             r_phase, w_phase_nxt;
  logic             r_jump_prev, r_armed;
  logic             w_go_left, w_go_right, w_dir_any, w_h_move;
  logic             w_on_ground, w_jump_edge, w_jump_start;
  logic             w_in_jump, w_jump_wrap, w_anim_wrap, w_walk_nxt;
  logic signed [H_CALC_W-1:0] w_h_calc;

  assign w_go_left  = btn_left & ~btn_right;
  assign w_go_right = btn_right & ~btn_left;
  assign w_dir_any  = w_go_left | w_go_right;

  // r_armed blocks a button already held through reset from reading as a fresh edge.
  assign w_jump_edge  = frame_tick & btn_jump & ~r_jump_prev & r_armed;
  assign w_on_ground  = (r_state == ST_STAND) | (r_state == ST_WALK);
  assign w_in_jump    = (r_state == ST_JUMP_UP) | (r_state == ST_JUMP_DOWN);
  assign w_jump_start = w_on_ground & w_jump_edge;

  assign w_h_calc = w_go_left ? ($signed({1'b0, r_curr_h}) - $signed(H_CALC_W'(STEP)))
                              : ($signed({1'b0, r_curr_h}) + $signed(H_CALC_W'(STEP)));
  assign w_h_step = clamp_h(w_h_calc, $signed(H_CALC_W'(H_MIN)), $signed(H_CALC_W'(H_MAX)));
  assign w_h_nxt  = w_h_move ? w_h_step : r_curr_h;

  mario_frame_cnt #(.MAX(JUMP_FRAMES)) u_jump_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (frame_tick & w_in_jump),
    .i_clr    (w_jump_start),
    .o_wrap_c (w_jump_wrap)
  );

  // Next state and datapath updates; everything holds between frame ticks.
  always_comb begin
    w_state_nxt  = r_state;
    w_v_nxt      = r_curr_v;
    w_ground_nxt = r_ground_v;
    w_face_nxt   = r_facing;
    w_h_move     = 1'b0;
    if (frame_tick) begin
      case (r_state)
        ST_STAND, ST_WALK: begin
          if (w_dir_any) begin
            w_face_nxt = w_go_left;
          end
          if (w_jump_start) begin
            w_ground_nxt = r_curr_v;
            w_state_nxt  = ST_JUMP_UP;
          end else if (!w_dir_any) begin
            w_state_nxt = ST_STAND;
          end else begin
            w_state_nxt = ST_WALK;
            w_h_move    = 1'b1;
          end
        end
        ST_JUMP_UP: begin
          w_v_nxt = r_curr_v - POS_W'(JUMP_STEP);
          if (AIR_CTRL && w_dir_any) begin
            w_face_nxt = w_go_left;
            w_h_move   = 1'b1;
          end
          if (w_jump_wrap) begin
            w_state_nxt = ST_JUMP_DOWN;
          end
        end
        ST_JUMP_DOWN: begin
          w_v_nxt = r_curr_v + POS_W'(JUMP_STEP);
          if (AIR_CTRL && w_dir_any) begin
            w_face_nxt = w_go_left;
            w_h_move   = 1'b1;
          end
          if (w_jump_wrap) begin
            w_v_nxt     = r_ground_v;
            w_state_nxt = ST_STAND;
          end
        end
        default: w_state_nxt = ST_STAND;
      endcase
    end
  end

  assign w_walk_nxt = (w_state_nxt == ST_WALK);

  mario_frame_cnt #(.MAX(ANIM_FRAMES)) u_anim_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (frame_tick & w_walk_nxt),
    .i_clr    (frame_tick & ~w_walk_nxt),
    .o_wrap_c (w_anim_wrap)
  );

  assign w_phase_nxt  = w_walk_nxt ? (r_phase ^ w_anim_wrap) : 1'b0;
  assign w_sprite_nxt = ((w_state_nxt == ST_JUMP_UP) || (w_state_nxt == ST_JUMP_DOWN)) ? SPR_JUMP :
                        (w_phase_nxt ? SPR_MOVE : SPR_STAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STAND;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curr_h    <= POS_W'(H_START);
      r_curr_v    <= POS_W'(V_START);
      r_ground_v  <= POS_W'(V_START);
      r_facing    <= 1'b0;
      r_phase     <= 1'b0;
      r_sprite    <= SPR_STAND;
      r_jump_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else if (frame_tick) begin
      r_curr_h    <= w_h_nxt;
      r_curr_v    <= w_v_nxt;
      r_ground_v  <= w_ground_nxt;
      r_facing    <= w_face_nxt;
      r_phase     <= w_phase_nxt;
      r_sprite    <= w_sprite_nxt;
      r_jump_prev <= btn_jump;
      r_armed     <= 1'b1;
    end
  end

  assign curr_h       = r_curr_h;
  assign curr_v       = r_curr_v;
  assign sprite_selec = r_sprite;
  assign facing_left  = r_facing;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Self-checking bench for mario_motion_ctrl: directed scenarios plus a random run
// checked against a tick-level behavioural model.
module tb_mario_motion_ctrl;

  localparam int H_START     = 40;
  localparam int V_START     = 416;
  localparam int H_MIN       = 0;
  localparam int H_MAX       = 608;
  localparam int STEP        = 2;
  localparam int JUMP_STEP   = 4;
  localparam int JUMP_FRAMES = 8;
  localparam int ANIM_FRAMES = 6;

`ifdef MARIO_AIR_CONTROL_EN
  localparam bit AIR = 1'b1;
`else
  localparam bit AIR = 1'b0;
`endif

  logic       clk, rst_n, frame_tick, btn_left, btn_right, btn_jump;
  logic [9:0] curr_h, curr_v;
  logic [1:0] sprite_selec;
  logic       facing_left;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_h, m_v, m_ground, m_spr, m_jt, m_walk;
  bit m_face, m_injump, m_prev, m_armed;

  mario_motion_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .curr_h       (curr_h),
    .curr_v       (curr_v),
    .sprite_selec (sprite_selec),
    .facing_left  (facing_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp_model(input int x);
    if (x < H_MIN) return H_MIN;
    if (x > H_MAX) return H_MAX;
    return x;
  endfunction

  task automatic model_reset();
    m_h = H_START; m_v = V_START; m_ground = V_START; m_spr = 0;
    m_jt = 0; m_walk = 0; m_face = 0; m_injump = 0; m_prev = 0; m_armed = 0;
  endtask

  // One frame of the game rules: walking counts frames, a jump is a 2*JUMP_FRAMES arc.
  task automatic model_step(input logic l, input logic r, input logic j);
    int  dir;
    bit  edge_seen;
    dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    edge_seen = m_armed && j && !m_prev;
    if (m_injump) begin
      m_jt++;
      m_v = m_ground - JUMP_STEP * ((m_jt <= JUMP_FRAMES) ? m_jt : 2 * JUMP_FRAMES - m_jt);
      if (AIR && dir != 0) begin
        m_h = clamp_model(m_h + STEP * dir);
        m_face = (dir < 0);
      end
      if (m_jt == 2 * JUMP_FRAMES) begin
        m_injump = 0;
        m_walk = 0;
      end
    end else begin
      if (dir != 0) m_face = (dir < 0);
      if (edge_seen) begin
        m_injump = 1; m_jt = 0; m_ground = m_v; m_walk = 0;
      end else if (dir == 0) begin
        m_walk = 0;
      end else begin
        m_h = clamp_model(m_h + STEP * dir);
        m_walk++;
      end
    end
    m_prev = j;
    m_armed = 1;
    m_spr = m_injump ? 2 : ((m_walk / ANIM_FRAMES) % 2);
  endtask

  // Drive one frame tick, then idle 0-2 cycles with button noise that must be ignored.
  task automatic do_tick(input logic l, input logic r, input logic j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    model_step(l, r, j);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      btn_left = 1'($urandom); btn_right = 1'($urandom); btn_jump = 1'($urandom);
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (curr_h !== 10'd40 || curr_v !== 10'd416 || sprite_selec !== 2'b00 || facing_left !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: got h=%0d v=%0d spr=%0d face=%0d, expected 40/416/0/0",
               curr_h, curr_v, sprite_selec, facing_left);
    end
    for (int t = 1; t <= 3; t++) begin
      do_tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (curr_h !== 10'd40 || curr_v !== 10'd416 || sprite_selec !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_tick%0d: got h=%0d v=%0d spr=%0d, expected 40/416/0",
                 t, curr_h, curr_v, sprite_selec);
      end
    end
  endtask

  task automatic test_walk_right();
    logic [1:0] exp_spr;
    apply_reset();
    for (int t = 1; t <= 12; t++) begin
      do_tick(1'b0, 1'b1, 1'b0);
      exp_spr = (t >= 6 && t <= 11) ? 2'b01 : 2'b00;
      n_tests++;
      if (curr_h !== 10'(H_START + STEP * t) || sprite_selec !== exp_spr) begin
        n_fail++;
        $display("FAIL walk_right_t%0d: got h=%0d spr=%0d, expected h=%0d spr=%0d",
                 t, curr_h, sprite_selec, H_START + STEP * t, exp_spr);
      end
    end
    n_tests++;
    if (facing_left !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_right_face: got %0d expected 0", facing_left);
    end
    do_tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (sprite_selec !== 2'b00 || curr_h !== 10'd64) begin
      n_fail++;
      $display("FAIL walk_stop: got h=%0d spr=%0d, expected h=64 spr=0", curr_h, sprite_selec);
    end
  endtask

  task automatic test_walk_left_clamp();
    int exp_h;
    apply_reset();
    for (int t = 1; t <= 30; t++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      exp_h = (H_START - STEP * t < 0) ? 0 : H_START - STEP * t;
      n_tests++;
      if (curr_h !== 10'(exp_h) || facing_left !== 1'b1) begin
        n_fail++;
        $display("FAIL walk_left_t%0d: got h=%0d face=%0d, expected h=%0d face=1",
                 t, curr_h, facing_left, exp_h);
      end
    end
    n_tests++;
    if (sprite_selec !== 2'(m_spr)) begin
      n_fail++;
      $display("FAIL left_pinned_anim: got spr=%0d expected %0d", sprite_selec, m_spr);
    end
  endtask

  task automatic test_right_clamp();
    apply_reset();
    repeat (300) do_tick(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (curr_h !== 10'd608 || sprite_selec !== 2'(m_spr)) begin
      n_fail++;
      $display("FAIL right_clamp: got h=%0d spr=%0d, expected h=608 spr=%0d", curr_h, sprite_selec, m_spr);
    end
  endtask

  task automatic test_jump();
    int         exp_v;
    logic       j;
    logic [1:0] exp_spr;
    apply_reset();
    do_tick(1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 17; k++) begin
      j = (k < 3 || k >= 5) ? 1'b1 : 1'b0;
      do_tick(1'b0, 1'b0, j);
      exp_v   = V_START - JUMP_STEP * ((k <= JUMP_FRAMES) ? k : (k <= 16 ? 16 - k : 0));
      exp_spr = (k < 16) ? 2'b10 : 2'b00;
      n_tests++;
      if (curr_v !== 10'(exp_v) || sprite_selec !== exp_spr || curr_h !== 10'd40) begin
        n_fail++;
        $display("FAIL jump_k%0d: got v=%0d spr=%0d h=%0d, expected v=%0d spr=%0d h=40",
                 k, curr_v, sprite_selec, curr_h, exp_v, exp_spr);
      end
    end
    do_tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_jump_right();
    int exp_h;
    apply_reset();
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (curr_h !== 10'd40 || sprite_selec !== 2'b10) begin
      n_fail++;
      $display("FAIL jump_right_start: got h=%0d spr=%0d, expected h=40 spr=2", curr_h, sprite_selec);
    end
    for (int k = 1; k <= 16; k++) begin
      do_tick(1'b0, 1'b1, 1'b1);
      exp_h = AIR ? H_START + STEP * k : H_START;
      n_tests++;
      if (curr_h !== 10'(exp_h) || facing_left !== 1'b0) begin
        n_fail++;
        $display("FAIL jump_right_k%0d: got h=%0d face=%0d, expected h=%0d face=0",
                 k, curr_h, facing_left, exp_h);
      end
    end
    n_tests++;
    if (curr_v !== 10'd416 || sprite_selec !== 2'b00) begin
      n_fail++;
      $display("FAIL jump_right_land: got v=%0d spr=%0d, expected 416/0", curr_v, sprite_selec);
    end
  endtask

  task automatic test_reset_mid_jump();
    apply_reset();
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 1'b1);
    repeat (4) do_tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (curr_v !== 10'd400) begin
      n_fail++;
      $display("FAIL pre_reset_v: got %0d expected 400", curr_v);
    end
    @(negedge clk);
    btn_jump = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (curr_h !== 10'd40 || curr_v !== 10'd416 || sprite_selec !== 2'b00 || facing_left !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got h=%0d v=%0d spr=%0d face=%0d, expected 40/416/0/0",
               curr_h, curr_v, sprite_selec, facing_left);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int t = 1; t <= 2; t++) begin
      do_tick(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (curr_v !== 10'd416 || sprite_selec !== 2'b00) begin
        n_fail++;
        $display("FAIL held_jump_after_reset_t%0d: got v=%0d spr=%0d, expected 416/0",
                 t, curr_v, sprite_selec);
      end
    end
    do_tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic l, r, j;
    apply_reset();
    l = 1'b0; r = 1'b0; j = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        l = 1'($urandom); r = 1'($urandom);
      end
      if ($urandom_range(0, 5) == 0) j = ~j;
      do_tick(l, r, j);
      n_tests++;
      if (curr_h !== 10'(m_h) || curr_v !== 10'(m_v) ||
          sprite_selec !== 2'(m_spr) || facing_left !== m_face) begin
        n_fail++;
        $display("FAIL rand_tick%0d: got h=%0d v=%0d spr=%0d face=%0d, expected h=%0d v=%0d spr=%0d face=%0d",
                 i, curr_h, curr_v, sprite_selec, facing_left, m_h, m_v, m_spr, m_face);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    model_reset();
    test_reset();
    test_walk_right();
    test_walk_left_clamp();
    test_right_clamp();
    test_jump();
    test_jump_right();
    test_reset_mid_jump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
